// File: rtl/bb_bus_pkg.sv
// Shared types and defaults for the bit-serial system bus arbiter.
// Contents:
//   NUM_MASTERS_DEF, MAX_HOLD_DEF : default parameter values
//   arb_state_t                   : arbiter FSM state encoding
//   idx_w()                       : width of a master-index field for n masters
package bb_bus_pkg;

    localparam int unsigned NUM_MASTERS_DEF = 4;
    localparam int unsigned MAX_HOLD_DEF    = 256;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Master-index width; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bb_rr_picker.sv
// Combinational round-robin picker: the first requester after ptr wins.
// Ports:
//   req     in  N   request vector
//   ptr     in  IW  index of the last granted master
//   gnt_c   out N   one-hot winner
//   idx_c   out IW  index of the winner
//   valid_c out 1   at least one requester present
module bb_rr_picker
    import bb_bus_pkg::*;
#(
    parameter int unsigned N  = NUM_MASTERS_DEF,
    localparam int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_c,
    output logic [IW-1:0] idx_c,
    output logic          valid_c
);

    // Scan ptr+1 .. ptr+N (mod N); the last granted master comes up last.
    always_comb begin
        logic [IW-1:0] k;
        gnt_c   = '0;
        idx_c   = '0;
        valid_c = 1'b0;
        k       = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            k = IW'((32'(ptr) + i) % N);
            if (!valid_c && req[k]) begin
                valid_c  = 1'b1;
                idx_c    = k;
                gnt_c[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bb_bus_arbiter.sv
// Central arbiter for the shared bit-serial bus with split-transaction
// bookkeeping: parks a split master, lends the bus to others, and re-grants
// the parked master first once its slave releases the split.
// Optional grant-hold watchdog enabled by defining BB_ARB_WATCHDOG_EN.
// Ports:
//   clk, rstn         bus clock, async active-low reset
//   breq              per-master level request
//   bgrant            registered one-hot grant
//   msel              index of granted master (holds last grant when idle)
//   bus_busy          a grant is active
//   slave_split_req   pulse: slave splits the current transaction
//   slave_split_rel   pulse: split slave ready to return data
//   split_m           per-master split line
//   split_pending     a split is outstanding
//   split_overflow    pulse: a split request was refused
//   wd_revoke         pulse: watchdog revoked a grant (watchdog builds only)
module bb_bus_arbiter
    import bb_bus_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = NUM_MASTERS_DEF,
    parameter int unsigned MAX_HOLD    = MAX_HOLD_DEF,
    localparam int unsigned IW = idx_w(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_MASTERS-1:0] breq,
    output logic [NUM_MASTERS-1:0] bgrant,
    output logic [IW-1:0]          msel,
    output logic                   bus_busy,
    input  logic                   slave_split_req,
    input  logic                   slave_split_rel,
    output logic [NUM_MASTERS-1:0] split_m,
    output logic                   split_pending,
    output logic                   split_overflow
`ifdef BB_ARB_WATCHDOG_EN
    ,
    output logic                   wd_revoke
`endif
);

    arb_state_t             state_q, state_d;
    logic [NUM_MASTERS-1:0] bgrant_d, split_m_d, cand;
    logic [IW-1:0]          msel_d, ptr_q, ptr_d, owner_q, owner_d;
    logic                   bus_busy_d, split_pending_d, split_overflow_d;
    logic                   split_ready_q, split_ready_d;
    logic [NUM_MASTERS-1:0] pick_gnt;
    logic [IW-1:0]          pick_idx;
    logic                   pick_valid;

`ifdef BB_ARB_WATCHDOG_EN
    localparam int unsigned HW = $clog2(MAX_HOLD) + 1;
    logic [HW-1:0]          hold_q, hold_d;
    logic [NUM_MASTERS-1:0] blocked_q, blocked_d;
    logic                   wd_revoke_d;
`else
    logic [31:0] unused_max_hold;
    assign unused_max_hold = 32'(MAX_HOLD);
`endif

    // Parked owner sits out arbitration until its split is released.
    always_comb begin
        cand = breq;
        if (split_pending && !split_ready_q) begin
            cand[owner_q] = 1'b0;
        end
`ifdef BB_ARB_WATCHDOG_EN
        cand = cand & ~blocked_q;
`endif
    end

    bb_rr_picker #(.N(NUM_MASTERS)) u_picker (
        .req     (cand),
        .ptr     (ptr_q),
        .gnt_c   (pick_gnt),
        .idx_c   (pick_idx),
        .valid_c (pick_valid)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d          = state_q;
        bgrant_d         = bgrant;
        msel_d           = msel;
        bus_busy_d       = bus_busy;
        split_m_d        = split_m;
        split_pending_d  = split_pending;
        split_overflow_d = 1'b0;
        split_ready_d    = split_ready_q;
        owner_d          = owner_q;
        ptr_d            = ptr_q;
`ifdef BB_ARB_WATCHDOG_EN
        hold_d           = hold_q;
        blocked_d        = blocked_q & breq;
        wd_revoke_d      = 1'b0;
`endif

        if (split_pending && slave_split_rel) begin
            split_ready_d = 1'b1;
        end
        // Owner abandoned its parked transaction.
        if (split_pending && !breq[owner_q]) begin
            split_pending_d = 1'b0;
            split_ready_d   = 1'b0;
            split_m_d       = '0;
        end

        case (state_q)
            IDLE: begin
                bgrant_d   = '0;
                bus_busy_d = 1'b0;
                if (slave_split_req) begin
                    split_overflow_d = 1'b1;
                end
                if (split_pending && split_ready_q && breq[owner_q]) begin
                    // split_m is one-hot on the owner, so it doubles as its grant.
                    state_d         = BUSY;
                    bgrant_d        = split_m;
                    msel_d          = owner_q;
                    bus_busy_d      = 1'b1;
                    ptr_d           = owner_q;
                    split_m_d       = '0;
                    split_pending_d = 1'b0;
                    split_ready_d   = 1'b0;
`ifdef BB_ARB_WATCHDOG_EN
                    hold_d          = '0;
`endif
                end else if (pick_valid) begin
                    state_d    = BUSY;
                    bgrant_d   = pick_gnt;
                    msel_d     = pick_idx;
                    bus_busy_d = 1'b1;
                    ptr_d      = pick_idx;
`ifdef BB_ARB_WATCHDOG_EN
                    hold_d     = '0;
`endif
                end
            end
            BUSY: begin
                if (!breq[msel]) begin
                    // Release beats a same-cycle split request.
                    state_d    = IDLE;
                    bgrant_d   = '0;
                    bus_busy_d = 1'b0;
                end else if (slave_split_req) begin
                    if (!split_pending) begin
                        state_d         = IDLE;
                        bgrant_d        = '0;
                        bus_busy_d      = 1'b0;
                        owner_d         = msel;
                        split_pending_d = 1'b1;
                        split_m_d       = bgrant;
                    end else begin
                        split_overflow_d = 1'b1;
                    end
`ifdef BB_ARB_WATCHDOG_EN
                end else if (hold_q == HW'(MAX_HOLD - 1)) begin
                    state_d           = IDLE;
                    bgrant_d          = '0;
                    bus_busy_d        = 1'b0;
                    ptr_d             = msel;
                    blocked_d[msel]   = 1'b1;
                    wd_revoke_d       = 1'b1;
                end else begin
                    hold_d = hold_q + HW'(1);
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= IDLE;
            bgrant         <= '0;
            msel           <= '0;
            bus_busy       <= 1'b0;
            split_m        <= '0;
            split_pending  <= 1'b0;
            split_overflow <= 1'b0;
            split_ready_q  <= 1'b0;
            owner_q        <= '0;
            ptr_q          <= IW'(NUM_MASTERS - 1);
`ifdef BB_ARB_WATCHDOG_EN
            hold_q         <= '0;
            blocked_q      <= '0;
            wd_revoke      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            bgrant         <= bgrant_d;
            msel           <= msel_d;
            bus_busy       <= bus_busy_d;
            split_m        <= split_m_d;
            split_pending  <= split_pending_d;
            split_overflow <= split_overflow_d;
            split_ready_q  <= split_ready_d;
            owner_q        <= owner_d;
            ptr_q          <= ptr_d;
`ifdef BB_ARB_WATCHDOG_EN
            hold_q         <= hold_d;
            blocked_q      <= blocked_d;
            wd_revoke      <= wd_revoke_d;
`endif
        end
    end

endmodule
